ntt_engine_seq: RTL

- Sequential, parametrised NTT/INTT engine for the Kyber polynomial arithmetic datapath, successor to the purely combinational inverse transform.
- One modular butterfly shared over all layers; forward or inverse mode selected per job.
- Coefficients are streamed in and out with valid/ready handshakes and held in an internal N-entry register array.
- Outputs are always canonical, in the range [0, Q-1].

---
 rtl/ntt_engine_seq.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/ntt_engine_seq.sv
// rtl/ntt_engine_seq.sv - sequential Kyber NTT/INTT engine sharing one modular butterfly
module ntt_engine_seq #(
    parameter int N     = 256,
    parameter int Q     = 3329,
    parameter int WIDTH = 16,
    parameter int F     = 3303
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             done
);
    localparam int AW = $clog2(N);
    localparam int KW = AW - 1;
    localparam int PW = 2 * WIDTH;
    localparam logic [WIDTH-1:0] QW = WIDTH'(Q);
    localparam logic [WIDTH-1:0] FW = WIDTH'(F);

    // Bit-reversed powers of zeta = 17 mod 3329
    localparam logic [11:0] ZETA [0:127] = '{
        12'd1,    12'd1729, 12'd2580, 12'd3289, 12'd2642, 12'd630,  12'd1897, 12'd848,
        12'd1062, 12'd1919, 12'd193,  12'd797,  12'd2786, 12'd3260, 12'd569,  12'd1746,
        12'd296,  12'd2447, 12'd1339, 12'd1476, 12'd3046, 12'd56,   12'd2240, 12'd1333,
        12'd1426, 12'd2094, 12'd535,  12'd2882, 12'd2393, 12'd2879, 12'd1974, 12'd821,
        12'd289,  12'd331,  12'd3253, 12'd1756, 12'd1197, 12'd2304, 12'd2277, 12'd2055,
        12'd650,  12'd1977, 12'd2513, 12'd632,  12'd2865, 12'd33,   12'd1320, 12'd1915,
        12'd2319, 12'd1435, 12'd807,  12'd452,  12'd1438, 12'd2868, 12'd1534, 12'd2402,
        12'd2647, 12'd2617, 12'd1481, 12'd648,  12'd2474, 12'd3110, 12'd1227, 12'd910,
        12'd17,   12'd2761, 12'd583,  12'd2649, 12'd1637, 12'd723,  12'd2288, 12'd1100,
        12'd1409, 12'd2662, 12'd3281, 12'd233,  12'd756,  12'd2156, 12'd3015, 12'd3050,
        12'd1703, 12'd1651, 12'd2789, 12'd1789, 12'd1847, 12'd952,  12'd1461, 12'd2687,
        12'd939,  12'd2308, 12'd2437, 12'd2388, 12'd733,  12'd2337, 12'd268,  12'd641,
        12'd1584, 12'd2298, 12'd2037, 12'd3220, 12'd375,  12'd2549, 12'd2090, 12'd1645,
        12'd1063, 12'd319,  12'd2773, 12'd757,  12'd2099, 12'd561,  12'd2466, 12'd2594,
        12'd2804, 12'd1092, 12'd403,  12'd1026, 12'd1143, 12'd2150, 12'd2775, 12'd886,
        12'd1722, 12'd1212, 12'd1874, 12'd1029, 12'd2110, 12'd2935, 12'd885,  12'd2154
    };

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CALC, S_SCALE, S_UNLOAD} state_t;

    state_t            state_q, state_d;
    logic              mode_q, mode_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic [AW-1:0]     j_q, j_d;
    logic [AW-1:0]     len_q, len_d;
    logic [KW-1:0]     k_q, k_d;
    logic              done_q, done_d;
    logic [WIDTH-1:0]  f_q [N];
    logic [WIDTH-1:0]  f_d [N];

    logic [WIDTH-1:0]  in_red;
    logic [AW-1:0]     hi_idx, len_m1;
    logic [AW:0]       next_blk;
    logic              blk_end, layer_end, last_bf;
    logic [WIDTH-1:0]  bf_a, bf_b, bf_t, bf_lo, bf_hi, zeta;

    // Operands are always canonical, so a single conditional subtract suffices
    function automatic logic [WIDTH-1:0] mod_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= (WIDTH+1)'(Q)) s = s - (WIDTH+1)'(Q);
        return s[WIDTH-1:0];
    endfunction

    // a - b computed as a + Q - b so the intermediate never goes negative
    function automatic logic [WIDTH-1:0] mod_sub(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH:0] s;
        s = {1'b0, a} + {1'b0, QW} - {1'b0, b};
        if (s >= (WIDTH+1)'(Q)) s = s - (WIDTH+1)'(Q);
        return s[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] mod_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [PW-1:0] p;
        p = PW'(a) * PW'(b);
        return WIDTH'(p % PW'(Q));
    endfunction

    // Shared butterfly on the pair (j, j+len); direction follows the latched mode
    always_comb begin
        hi_idx = j_q + len_q;
        bf_a   = f_q[j_q];
        bf_b   = f_q[hi_idx];
        zeta   = WIDTH'(ZETA[k_q]);
        in_red = (in_data >= QW) ? in_data - QW : in_data;
        if (!mode_q) begin
            bf_t  = mod_mul(zeta, bf_b);
            bf_lo = mod_add(bf_a, bf_t);
            bf_hi = mod_sub(bf_a, bf_t);
        end else begin
            bf_t  = mod_sub(bf_b, bf_a);
            bf_lo = mod_add(bf_a, bf_b);
            bf_hi = mod_mul(zeta, bf_t);
        end
    end

    // Loop bookkeeping: detect end of block, end of layer and the final butterfly
    always_comb begin
        len_m1    = len_q - AW'(1);
        blk_end   = (j_q & len_m1) == len_m1;
        next_blk  = {1'b0, j_q} + {1'b0, len_q} + (AW+1)'(1);
        layer_end = blk_end && next_blk[AW];
        last_bf   = layer_end && (mode_q ? (len_q == AW'(N/2)) : (len_q == AW'(2)));
    end

    // Next-state, schedule counters and coefficient array updates
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        j_d     = j_q;
        len_d   = len_q;
        k_d     = k_q;
        done_d  = 1'b0;
        f_d     = f_q;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    mode_d  = mode;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    f_d[cnt_q] = in_red;
                    cnt_d      = cnt_q + AW'(1);
                    if (cnt_q == AW'(N-1)) begin
                        state_d = S_CALC;
                        j_d     = '0;
                        len_d   = mode_q ? AW'(2) : AW'(N/2);
                        k_d     = mode_q ? KW'(N/2-1) : KW'(1);
                    end
                end
            end
            S_CALC: begin
                f_d[j_q]    = bf_lo;
                f_d[hi_idx] = bf_hi;
                if (blk_end) begin
                    k_d = mode_q ? k_q - KW'(1) : k_q + KW'(1);
                    if (layer_end) begin
                        j_d   = '0;
                        len_d = mode_q ? len_q << 1 : len_q >> 1;
                    end else begin
                        j_d = next_blk[AW-1:0];
                    end
                end else begin
                    j_d = j_q + AW'(1);
                end
                if (last_bf) begin
                    cnt_d   = '0;
                    state_d = mode_q ? S_SCALE : S_UNLOAD;
                end
            end
            S_SCALE: begin
                f_d[cnt_q] = mod_mul(f_q[cnt_q], FW);
                cnt_d      = cnt_q + AW'(1);
                if (cnt_q == AW'(N-1)) state_d = S_UNLOAD;
            end
            S_UNLOAD: begin
                if (out_ready) begin
                    cnt_d = cnt_q + AW'(1);
                    if (cnt_q == AW'(N-1)) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
            cnt_q   <= '0;
            j_q     <= '0;
            len_q   <= '0;
            k_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            j_q     <= j_d;
            len_q   <= len_d;
            k_q     <= k_d;
            done_q  <= done_d;
        end
    end

    // Coefficient storage carries no reset; contents are rewritten by every job
    always_ff @(posedge clk) begin
        f_q <= f_d;
    end

    assign busy      = (state_q != S_IDLE);
    assign in_ready  = (state_q == S_LOAD);
    assign out_valid = (state_q == S_UNLOAD);
    assign out_data  = (state_q == S_UNLOAD) ? f_q[cnt_q] : '0;
    assign out_last  = (state_q == S_UNLOAD) && (cnt_q == AW'(N-1));
    assign done      = done_q;

endmodule
